// File: rtl/fft_reorder_buffer_pkg.sv
// Shared types and helpers for the FFT output reorder buffer.
// complex_product_t is the butterfly output sample, already saturated upstream.
package fft_reorder_buffer_pkg;

  localparam int R     = 16;
  localparam int FFT_N = 64;

  localparam logic signed [R-1:0] FIXED_POINT_MAX = {1'b0, {(R-1){1'b1}}};
  localparam logic signed [R-1:0] FIXED_POINT_MIN = {1'b1, {(R-1){1'b0}}};

  typedef struct packed {
    logic signed [R-1:0] re;
    logic signed [R-1:0] im;
  } complex_product_t;

  // Widest index the bit reversal supports (N up to 1024)
  localparam int BITREV_W = 10;

  // Reverse the low 'width' bits of idx; upper result bits come out zero
  function automatic logic [BITREV_W-1:0] bitrev(input logic [BITREV_W-1:0] idx,
                                                 input int width);
    logic [BITREV_W-1:0] rev;
    rev = '0;
    for (int b = 0; b < BITREV_W; b++) begin
      rev[b] = idx[BITREV_W-1-b];
    end
    return rev >> (BITREV_W - width);
  endfunction

endpackage

// File: rtl/fft_reorder_buffer_bank.sv
// fft_reorder_bank: one frame of complex samples, synchronous write,
// asynchronous read. Contents are not reset; validity is tracked by the owner.
module fft_reorder_bank
  import fft_reorder_buffer_pkg::*;
#(
  parameter  int N     = FFT_N,
  localparam int LOG2N = $clog2(N)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [LOG2N-1:0] waddr,
  input  complex_product_t wdata,
  input  logic [LOG2N-1:0] raddr,
  output complex_product_t rdata
);

  complex_product_t mem [N];

  // Store one sample per accepted write
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fft_reorder_buffer.sv
// fft_reorder_buffer: converts bit-reversed FFT frames to natural order with
// a two-bank ping-pong buffer. Writes scatter to bitrev(wr_cnt); reads walk
// linearly. Optional build macro FFT_REORDER_OVF_EN adds a sticky overflow
// flag for dropped input samples and a 16-bit completed-frame counter.
module fft_reorder_buffer
  import fft_reorder_buffer_pkg::*;
#(
  parameter  int N     = FFT_N,
  localparam int LOG2N = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  complex_product_t in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output complex_product_t out_data,
  output logic [LOG2N-1:0] out_index,
  output logic             out_sop,
  output logic             out_eop
`ifdef FFT_REORDER_OVF_EN
  ,
  output logic             overflow,
  output logic [15:0]      frames_done
`endif
);

  logic             wr_bank;
  logic             rd_bank;
  logic [LOG2N-1:0] wr_cnt;
  logic [LOG2N-1:0] rd_cnt;
  logic [1:0]       full;
  logic [1:0]       full_nxt;

  logic             accept;
  logic             xfer;
  logic             wr_last;
  logic             rd_last;
  logic [LOG2N-1:0] waddr;
  logic [1:0]       we;
  complex_product_t rdata [2];

  // Both handshakes depend only on registered state, so out_ready never
  // reaches in_ready combinationally.
  assign in_ready  = !full[wr_bank];
  assign out_valid = full[rd_bank];
  assign accept    = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;
  assign wr_last   = (wr_cnt == LOG2N'(N-1));
  assign rd_last   = (rd_cnt == LOG2N'(N-1));

  assign waddr = LOG2N'(bitrev(BITREV_W'(wr_cnt), LOG2N));
  assign we[0] = accept && !flush && !wr_bank;
  assign we[1] = accept && !flush &&  wr_bank;

  fft_reorder_bank #(.N(N)) u_bank0 (
    .clk   (clk),
    .we    (we[0]),
    .waddr (waddr),
    .wdata (in_data),
    .raddr (rd_cnt),
    .rdata (rdata[0])
  );

  fft_reorder_bank #(.N(N)) u_bank1 (
    .clk   (clk),
    .we    (we[1]),
    .waddr (waddr),
    .wdata (in_data),
    .raddr (rd_cnt),
    .rdata (rdata[1])
  );

  assign out_data  = out_valid ? rdata[rd_bank] : '0;
  assign out_index = rd_cnt;
  assign out_sop   = out_valid && (rd_cnt == '0);
  assign out_eop   = out_valid && rd_last;

  // Fill and release of the two banks are independent; write and read never
  // share a bank while both are active.
  always_comb begin
    full_nxt = full;
    if (accept && wr_last) full_nxt[wr_bank] = 1'b1;
    if (xfer && rd_last)   full_nxt[rd_bank] = 1'b0;
  end

  // Write/read pointers and bank-full flags; flush wins over any handshake
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      full    <= 2'b00;
    end else if (flush) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      full    <= 2'b00;
    end else begin
      if (accept) begin
        wr_cnt <= wr_cnt + LOG2N'(1);
        if (wr_last) wr_bank <= !wr_bank;
      end
      if (xfer) begin
        rd_cnt <= rd_cnt + LOG2N'(1);
        if (rd_last) rd_bank <= !rd_bank;
      end
      full <= full_nxt;
    end
  end

`ifdef FFT_REORDER_OVF_EN
  // Sticky drop flag and wrapping count of frames fully delivered downstream
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow    <= 1'b0;
      frames_done <= '0;
    end else if (flush) begin
      overflow    <= 1'b0;
      frames_done <= '0;
    end else begin
      if (in_valid && !in_ready) overflow <= 1'b1;
      if (xfer && out_eop) frames_done <= frames_done + 16'd1;
    end
  end
`endif

endmodule
